cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_if.sv | 26 ++
 rtl/cache_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
// Bus bundle between the EXE/MEM stage, the cache controller and the SRAM controller.
// The slave modport is the cache controller; the master is the environment (pipeline + SRAM).
interface cache_controller_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_mem_r_en;
  logic        sram_mem_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_mem_r_en, sram_mem_w_en
  );

  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_mem_r_en, sram_mem_w_en
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through / no-write-allocate data cache in front of an SRAM
// controller; read hits complete in zero cycles, misses fetch a 64-bit line.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  parameter int BASE  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);

  localparam int          IDX_W    = $clog2(SETS);
  localparam int          TAG_LSB  = 3 + IDX_W;
  localparam logic [31:0] BASE_OFS = 32'(BASE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RMISS = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [SETS-1:0]  r_lru;

  logic [31:0]      w_addr;
  logic             w_word;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_unused;

  logic [1:0]       w_hit;
  logic [1:0]       w_valid;
  logic [31:0]      w_way_word [2];
  logic             w_hit_any;
  logic             w_hit_way;
  logic             w_victim;

  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_idle;
  logic             w_fill_en;
  logic             w_whit_en;
  logic             w_rhit_en;

  logic [31:0]      w_rdata;
  logic             w_ready;
  logic             w_sram_r_en;
  logic             w_sram_w_en;

  assign w_addr   = bus.address - BASE_OFS;
  assign w_word   = w_addr[2];
  assign w_idx    = w_addr[3 +: IDX_W];
  assign w_tag    = w_addr[TAG_LSB +: TAG_W];
  assign w_unused = &{1'b0, w_addr[1:0], w_addr[31:TAG_LSB+TAG_W]};

  // A store wins over a load when both enables are raised together.
  assign w_wr_req = bus.MEM_W_EN;
  assign w_rd_req = bus.MEM_R_EN & ~bus.MEM_W_EN;

  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_rhit_en = w_idle && w_rd_req && w_hit_any;
  assign w_whit_en = w_idle && w_wr_req && w_hit_any;
  assign w_fill_en = (r_state == S_RMISS) && bus.sram_ready && !rst;

  assign w_hit_any = |w_hit;
  assign w_hit_way = w_hit[1];
  assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      localparam logic WAY = 1'(gi);

      logic [SETS-1:0]  r_valid;
      logic [TAG_W-1:0] r_tag  [SETS];
      logic [31:0]      r_even [SETS];
      logic [31:0]      r_odd  [SETS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= '0;
        end else if (w_fill_en && (w_victim == WAY)) begin
          r_valid[w_idx] <= 1'b1;
        end
      end

      // Tag/data storage carries no reset; valid bits alone qualify its contents.
      always_ff @(posedge clk) begin
        if (w_fill_en && (w_victim == WAY)) begin
          r_tag[w_idx]  <= w_tag;
          r_even[w_idx] <= bus.sram_rdata[31:0];
          r_odd[w_idx]  <= bus.sram_rdata[63:32];
        end else if (w_whit_en && (w_hit_way == WAY)) begin
          if (w_word) begin
            r_odd[w_idx] <= bus.wdata;
          end else begin
            r_even[w_idx] <= bus.wdata;
          end
        end
      end

      assign w_valid[gi]    = r_valid[w_idx];
      assign w_hit[gi]      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
      assign w_way_word[gi] = w_word ? r_odd[w_idx] : r_even[w_idx];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_rdata      = '0;
    w_ready      = 1'b1;
    w_sram_r_en  = 1'b0;
    w_sram_w_en  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_req) begin
            w_sram_w_en  = 1'b1;
            w_ready      = 1'b0;
            w_state_next = S_WRITE;
          end else if (w_rd_req) begin
            if (w_hit_any) begin
              w_rdata = w_way_word[w_hit_way];
            end else begin
              w_sram_r_en  = 1'b1;
              w_ready      = 1'b0;
              w_state_next = S_RMISS;
            end
          end
        end
        S_RMISS: begin
          w_sram_r_en = 1'b1;
          w_ready     = 1'b0;
          if (bus.sram_ready) begin
            w_ready      = 1'b1;
            w_rdata      = w_word ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
            w_state_next = S_IDLE;
          end
        end
        S_WRITE: begin
          w_sram_w_en = 1'b1;
          w_ready     = 1'b0;
          if (bus.sram_ready) begin
            w_ready      = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // LRU bit names the way that was NOT just touched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lru <= '0;
    end else if (w_rhit_en || w_whit_en) begin
      r_lru[w_idx] <= ~w_hit_way;
    end else if (w_fill_en) begin
      r_lru[w_idx] <= ~w_victim;
    end
  end

  assign bus.rdata         = w_rdata;
  assign bus.ready         = w_ready;
  assign bus.sram_mem_r_en = w_sram_r_en;
  assign bus.sram_mem_w_en = w_sram_w_en;
  assign bus.sram_address  = bus.address;
  assign bus.sram_wdata    = bus.wdata;

endmodule
